// File: rtl/bcs_group_encoder_pkg.sv
// Shared definitions for the bit-column sparsity group encoder.
// Provides the weight/magnitude widths, the sign-magnitude record type,
// the saturating two's complement -> sign-magnitude conversion and a
// 7-bit popcount used for the non-zero column count.
package bcs_group_encoder_pkg;

  localparam int MAG_W    = 7;
  localparam int WEIGHT_W = 8;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sign_mag_t;

  // -128 has no 7-bit magnitude; it saturates to 127 and keeps its sign.
  function automatic sign_mag_t to_sign_mag(input logic [WEIGHT_W-1:0] x);
    sign_mag_t           r;
    logic [WEIGHT_W-1:0] neg;
    neg    = ~x + 8'd1;
    r.sign = x[WEIGHT_W-1];
    if (x == 8'h80) begin
      r.mag = 7'h7f;
    end else if (x[WEIGHT_W-1]) begin
      r.mag = neg[MAG_W-1:0];
    end else begin
      r.mag = x[MAG_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] popcount7(input logic [MAG_W-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < MAG_W; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bcs_sm_convert.sv
// Converts one signed 8-bit weight into sign + 7-bit magnitude.
// Ports:
//   weight_i  two's complement weight
//   sign_o    1 = negative (0 for zero)
//   mag_o     |weight|, -128 saturated to 127
module bcs_sm_convert
  import bcs_group_encoder_pkg::*;
(
  input  logic [WEIGHT_W-1:0] weight_i,
  output logic                sign_o,
  output logic [MAG_W-1:0]    mag_o
);

  sign_mag_t sm;

  assign sm     = to_sign_mag(weight_i);
  assign sign_o = sm.sign;
  assign mag_o  = sm.mag;

endmodule

// File: rtl/bcs_group_encoder.sv
// Collects a group of signed weights over BEATS input beats, converts them to
// sign-magnitude, transposes the magnitudes into bit-columns and emits one
// registered group record (column index, columns, signs, popcount, zero flag).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 drops a partially assembled group (beat not accepted)
//   in_valid/in_ready     input beat handshake, in_data holds LANES weights
//   out_valid/out_ready   group record handshake
//   out_index             bit c set iff any magnitude has bit c set
//   out_cols              column c = out_cols[c*GROUP_SIZE +: GROUP_SIZE]
//   out_sign              per-weight sign
//   out_nzcnt, out_zero   popcount of out_index, out_index == 0
module bcs_group_encoder
  import bcs_group_encoder_pkg::*;
#(
  parameter int GROUP_SIZE = 8,
  parameter int LANES      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WEIGHT_W*LANES-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAG_W-1:0]            out_index,
  output logic [MAG_W*GROUP_SIZE-1:0] out_cols,
  output logic [GROUP_SIZE-1:0]       out_sign,
  output logic [2:0]                  out_nzcnt,
  output logic                        out_zero
);

  localparam int BEATS = GROUP_SIZE / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [MAG_W-1:0]            mag_buf_q [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]       sign_buf_q;

  logic [MAG_W-1:0]            lane_mag [LANES];
  logic [LANES-1:0]            lane_sign;

  logic [MAG_W-1:0]            grp_mag [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]       grp_sign;
  logic [MAG_W*GROUP_SIZE-1:0] cols_d;
  logic [MAG_W-1:0]            index_d;
  logic [2:0]                  nzcnt_d;

  logic                        out_valid_q, out_valid_d;
  logic [MAG_W-1:0]            out_index_q;
  logic [MAG_W*GROUP_SIZE-1:0] out_cols_q;
  logic [GROUP_SIZE-1:0]       out_sign_q;
  logic [2:0]                  out_nzcnt_q;
  logic                        out_zero_q;

  logic                        is_last;
  logic                        accept;
  logic                        load;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bcs_sm_convert u_conv (
      .weight_i (in_data[k*WEIGHT_W +: WEIGHT_W]),
      .sign_o   (lane_sign[k]),
      .mag_o    (lane_mag[k])
    );
  end

  // Only the final beat can be blocked, and only by an occupied,
  // non-draining output register.
  assign is_last  = (beat_cnt_q == LAST_BEAT);
  assign in_ready = !flush && (!is_last || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && is_last;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = is_last ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  // The record is only ever loaded on the final beat, so the last slot
  // always comes straight from the converters rather than the buffer.
  always_comb begin
    for (int w = 0; w < GROUP_SIZE; w++) begin
      grp_mag[w]  = mag_buf_q[w];
      grp_sign[w] = sign_buf_q[w];
      if (w / LANES == BEATS - 1) begin
        grp_mag[w]  = lane_mag[w % LANES];
        grp_sign[w] = lane_sign[w % LANES];
      end
    end
  end

  always_comb begin
    cols_d  = '0;
    index_d = '0;
    for (int w = 0; w < GROUP_SIZE; w++) begin
      index_d = index_d | grp_mag[w];
      for (int c = 0; c < MAG_W; c++) begin
        cols_d[c*GROUP_SIZE + w] = grp_mag[w][c];
      end
    end
    nzcnt_d = popcount7(index_d);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      sign_buf_q  <= '0;
      for (int w = 0; w < GROUP_SIZE; w++) begin
        mag_buf_q[w] <= '0;
      end
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_cols_q  <= '0;
      out_sign_q  <= '0;
      out_nzcnt_q <= '0;
      out_zero_q  <= 1'b1;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      for (int w = 0; w < GROUP_SIZE; w++) begin
        if (accept && !is_last && (w / LANES == int'(beat_cnt_q))) begin
          mag_buf_q[w]  <= lane_mag[w % LANES];
          sign_buf_q[w] <= lane_sign[w % LANES];
        end
      end
      if (load) begin
        out_index_q <= index_d;
        out_cols_q  <= cols_d;
        out_sign_q  <= grp_sign;
        out_nzcnt_q <= nzcnt_d;
        out_zero_q  <= (index_d == '0);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_cols  = out_cols_q;
  assign out_sign  = out_sign_q;
  assign out_nzcnt = out_nzcnt_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_bcs_group_encoder.sv
// Scoreboard bench for bcs_group_encoder: stimulus pushes expected group
// records computed from plain integer arithmetic; a monitor pops and compares
// each record as it is consumed and checks records stay stable while held.
module tb_bcs_group_encoder;
  localparam int G  = 8;
  localparam int L  = 2;
  localparam int MW = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [8*L-1:0] in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic [MW-1:0]  out_index;
  logic [MW*G-1:0] out_cols;
  logic [G-1:0]   out_sign;
  logic [2:0]     out_nzcnt;
  logic           out_zero;

  int n_vec = 0;
  int n_err = 0;
  int last_waits;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [MW-1:0]   idx;
    logic [MW*G-1:0] cols;
    logic [G-1:0]    sgn;
    logic [2:0]      cnt;
    logic            z;
  } rec_t;

  rec_t exp_q[$];
  int   pend[$];

  bcs_group_encoder #(.GROUP_SIZE(G), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_cols  (out_cols),
    .out_sign  (out_sign),
    .out_nzcnt (out_nzcnt),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*L-1:0] pk(input int a, input int b);
    logic [7:0] la, lb;
    la = 8'(a);
    lb = 8'(b);
    return {lb, la};
  endfunction

  function automatic int rw();
    int r;
    r = int'($urandom_range(0, 7));
    if (r <= 1) return 0;
    if (r == 2) return -128;
    if (r == 3) return 127;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Reference: weights in arrival order; a full group yields one record.
  task automatic model_accept(input logic [8*L-1:0] d);
    rec_t r;
    for (int k = 0; k < L; k++) begin
      logic signed [7:0] s;
      s = d[8*k +: 8];
      pend.push_back(int'(s));
    end
    if (pend.size() == G) begin
      r.idx = '0; r.cols = '0; r.sgn = '0; r.cnt = '0;
      for (int w = 0; w < G; w++) begin
        int x, m;
        x = pend[w];
        m = (x < 0) ? ((x == -128) ? 127 : -x) : x;
        r.sgn[w] = (x < 0);
        r.idx = r.idx | 7'(m);
        for (int c = 0; c < MW; c++) r.cols[c*G + w] = ((m >> c) & 1) == 1;
      end
      for (int c = 0; c < MW; c++) if (r.idx[c]) r.cnt = r.cnt + 3'd1;
      r.z = (r.idx == '0);
      exp_q.push_back(r);
      pend.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [8*L-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 200 cycles");
    end else begin
      model_accept(d);
    end
    last_waits = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin : rdy_gen
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : mon
    rec_t e;
    bit held;
    logic [MW-1:0] h_idx;
    logic [MW*G-1:0] h_cols;
    logic [G-1:0] h_sgn;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_index", 64'(out_index), 64'(h_idx));
          chk("hold_cols",  64'(out_cols),  64'(h_cols));
          chk("hold_sign",  64'(out_sign),  64'(h_sgn));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_record: got index %0h, expected no record", out_index);
          end else begin
            e = exp_q.pop_front();
            chk("rec_index", 64'(out_index), 64'(e.idx));
            chk("rec_cols",  64'(out_cols),  64'(e.cols));
            chk("rec_sign",  64'(out_sign),  64'(e.sgn));
            chk("rec_nzcnt", 64'(out_nzcnt), 64'(e.cnt));
            chk("rec_zero",  64'(out_zero),  64'(e.z));
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_idx  = out_index;
          h_cols = out_cols;
          h_sgn  = out_sign;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_cols",  64'(out_cols),  64'd0);
    chk("rst_sign",  64'(out_sign),  64'd0);
    chk("rst_nzcnt", 64'(out_nzcnt), 64'd0);
    chk("rst_zero",  64'(out_zero),  64'd1);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(in_ready), 64'd1);
    idle(1);

    // Mixed group with -128 saturation
    out_ready = 1'b1;
    send_beat(pk(3, -1));
    send_beat(pk(0, 0));
    send_beat(pk(4, 0));
    send_beat(pk(0, -128));
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_index", 64'(out_index), 64'h7f);
    chk("t1_nzcnt", 64'(out_nzcnt), 64'd7);
    chk("t1_sign",  64'(out_sign),  64'h82);
    chk("t1_col0",  64'(out_cols[G-1:0]), 64'h83);

    // All-zero group
    repeat (4) send_beat(pk(0, 0));
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_index", 64'(out_index), 64'd0);
    chk("t2_zero",  64'(out_zero),  64'd1);
    chk("t2_nzcnt", 64'(out_nzcnt), 64'd0);
    chk("t2_sign",  64'(out_sign),  64'd0);
    wait_drain();

    // Backpressure: held record, final beat of next group stalls
    out_ready = 1'b0;
    send_beat(pk(64, 0));
    repeat (3) send_beat(pk(0, 0));
    send_beat(pk(5, -3));
    chk("t3_nostall0", 64'(last_waits), 64'd0);
    send_beat(pk(0, 7));
    chk("t3_nostall1", 64'(last_waits), 64'd0);
    send_beat(pk(-128, 1));
    chk("t3_nostall2", 64'(last_waits), 64'd0);
    in_valid = 1'b1;
    in_data  = pk(2, 0);
    repeat (6) begin
      @(negedge clk);
      chk("t3_final_stall", 64'(in_ready), 64'd0);
      chk("t3_held_index", 64'(out_index), 64'h40);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_final_rdy", 64'(in_ready), 64'd1);
    if (in_ready) model_accept(pk(2, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_no_bubble", 64'(out_valid), 64'd1);
    chk("t3_b_index", 64'(out_index), 64'h7f);
    wait_drain();

    // Flush after two beats
    send_beat(pk(100, -100));
    send_beat(pk(50, 3));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = pk(127, 127);
    @(negedge clk);
    chk("t4_flush_rdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    pend.delete();
    send_beat(pk(1, 2));
    repeat (3) send_beat(pk(0, 0));
    chk("t4_index", 64'(out_index), 64'h03);
    chk("t4_nzcnt", 64'(out_nzcnt), 64'd2);
    wait_drain();

    // Flush on the final beat while a record is held
    out_ready = 1'b0;
    send_beat(pk(rw(), rw()));
    send_beat(pk(9, 0));
    send_beat(pk(rw(), rw()));
    send_beat(pk(rw(), rw()));
    repeat (3) send_beat(pk(33, -17));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = pk(1, 1);
    @(negedge clk);
    chk("t5_flush_rdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    pend.delete();
    chk("t5_valid_kept", 64'(out_valid), 64'd1);
    chk("t5_index_kept", 64'(out_index), 64'(exp_q[0].idx));
    out_ready = 1'b1;
    wait_drain();
    idle(3);
    chk("t5_no_record", 64'(out_valid), 64'd0);

    // Reset mid-group with a held record
    out_ready = 1'b0;
    repeat (4) send_beat(pk(rw(), rw()));
    send_beat(pk(11, 22));
    send_beat(pk(-5, 6));
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_index", 64'(out_index), 64'd0);
    chk("t6_cols",  64'(out_cols),  64'd0);
    chk("t6_sign",  64'(out_sign),  64'd0);
    chk("t6_nzcnt", 64'(out_nzcnt), 64'd0);
    chk("t6_zero",  64'(out_zero),  64'd1);
    exp_q.delete();
    pend.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_beat(pk(-7, 0));
    send_beat(pk(16, 0));
    send_beat(pk(0, 0));
    send_beat(pk(0, 1));
    chk("t6_after_index", 64'(out_index), 64'h17);
    wait_drain();

    // Randomized groups with random backpressure and idle gaps
    rand_rdy = 1'b1;
    for (int g = 0; g < 40; g++) begin
      for (int b = 0; b < G / L; b++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        send_beat(pk(rw(), rw()));
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcs_group_encoder.md
# bcs_group_encoder

Upstream feeder of the zero-column index pipeline. Collects a group of signed 8-bit weights over several input beats, converts each to sign-magnitude, transposes the 7 magnitude bits into bit-columns, and emits one registered group record: the 7-bit non-zero column index vector consumed by the index-processing stage, plus the column data and signs consumed by the bit-column engine. Valid/ready on both sides; sustains one input beat per cycle.

## Interface
- GROUP_SIZE, 8, weights per group; power of two, at least LANES
- LANES, 2, weights per input beat; divides GROUP_SIZE
- BEATS (localparam), GROUP_SIZE/LANES, beats per group
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of a partially assembled group
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  8*LANES  lane k = in_data[8k+7:8k], two's complement
- out_valid  out  1  group record valid
- out_ready  in  1  record consumed when out_valid & out_ready
- out_index  out  7  bit c = 1 iff some magnitude in the group has bit c set
- out_cols  out  7*GROUP_SIZE  column c = out_cols[c*GROUP_SIZE +: GROUP_SIZE]; bit w = magnitude bit c of weight w
- out_sign  out  GROUP_SIZE  sign of weight w (1 = negative, 0 for zero)
- out_nzcnt  out  3  popcount of out_index (0..7)
- out_zero  out  1  out_index == 0

## Operation
- Weight order: beat b, lane k -> weight w = b*LANES + k.
- Conversion: mag = |x|; x = -128 saturates to mag 127, sign 1; x = 0 gives sign 0.
- Assembly buffer: mags/signs written per beat at slot beat_cnt; beat_cnt counts 0..BEATS-1, wraps to 0 after the final beat.
- Final beat accept: the complete group (including the final beat's lanes, bypassing the buffer) is transposed, OR-reduced per column, popcounted and loaded into the output register; out_valid set.
- Output register holds stable while out_valid & !out_ready.
- in_ready = !flush & ((beat_cnt != BEATS-1) | !out_valid | out_ready). Non-final beats are never stalled; the final beat stalls only while the output register is occupied and not draining.
- Final beat accepted in the same cycle the previous record is consumed: new record loads, out_valid stays 1, no bubble.
- flush: beat_cnt <- 0, buffer contents irrelevant, in_ready = 0 that cycle (beat dropped, not accepted). Output register and out_valid unaffected.
- All-zero group: out_index = 0, out_nzcnt = 0, out_zero = 1, out_cols all 0; still emitted as a normal record.

## Timing
- Reset values: out_valid 0, out_index 0, out_cols 0, out_sign 0, out_nzcnt 0, out_zero 1; beat_cnt 0; in_ready 1 after reset deassertion (combinational, !flush).
- Latency: final beat accepted at edge N -> out_valid, out_index etc. visible after edge N; index stage registers them at edge N+1.
- Throughput: one group per BEATS cycles with out_ready held 1.
- Reset mid-group or mid-hold: partial group and pending record discarded, no output pulse.
- out_* change only on a load edge; never while out_valid & !out_ready.

## Structure
- Shared package: MAG_W = 7, WEIGHT_W = 8, functions to_sign_mag (with saturation) and popcount7.
- Sub-module bcs_sm_convert (one 8-bit weight -> sign, 7-bit mag), instantiated LANES times.
- Top: beat counter, assembly buffer, transpose/OR/popcount, output register, handshake.

## Test plan
- Defaults, beats {3,-1},{0,0},{4,0},{0,-128}, out_ready 1 -> out_index 7'b111_1111, out_nzcnt 7, out_sign 8'b1000_0010, column 0 = 8'b1000_0011.
- Group of all zeros -> out_index 0, out_zero 1, out_nzcnt 0, out_sign 0.
- Weights 64 at w=0, others 0, out_ready 0 for 10 cycles while next group streams -> first three beats accepted, final beat stalled (in_ready 0), record stable out_index 7'b100_0000; release out_ready -> second record loads next edge with no bubble.
- flush after 2 beats, then full group {1,2},{0,0},{0,0},{0,0} -> single record out_index 7'b000_0011, out_nzcnt 2; flushed beats never appear.
- flush asserted with in_valid on final beat -> in_ready 0, no record; output register of prior group unchanged.
- rst asserted mid-group with out_valid 1 -> out_valid 0, outputs at reset values immediately; next full group emitted correctly.
